// File: rtl/serial_pattern_tx.sv
// Serializes a captured word (PATTERN or i_data) LSB first, repeats it i_repeat+1
// times with GAP idle-level cycles after every frame, and pulses o_done when finished.
//
// Handshake: a request is accepted on the rising edge where i_valid=1 and o_ready=1.
// o_ready is high only in IDLE. Request inputs are ignored when no accept occurs.
module serial_pattern_tx #(
  parameter int               WIDTH      = 9,
  parameter logic [WIDTH-1:0] PATTERN    = 9'b101000111,
  parameter int               GAP        = 2,
  parameter logic             IDLE_LEVEL = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_sel_pattern,
  input  logic [3:0]       i_repeat,
  output logic             o_ready,
  output logic             s_data,
  output logic             o_busy,
  output logic             o_done,
  output logic [1:0]       o_state
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [3:0]       GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [3:0]       gap_cnt_q, gap_cnt_d;
  logic [3:0]       rep_cnt_q, rep_cnt_d;
  logic             sdata_q, sdata_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sel_word;

  assign sel_word = i_sel_pattern ? PATTERN : i_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      word_q    <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      rep_cnt_q <= '0;
      sdata_q   <= IDLE_LEVEL;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      rep_cnt_q <= rep_cnt_d;
      sdata_q   <= sdata_d;
      done_q    <= done_d;
    end
  end

  // s_data is always the registered next bit; the shifter holds the bits not yet sent.
  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    rep_cnt_d = rep_cnt_q;
    sdata_d   = IDLE_LEVEL;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          word_d    = sel_word;
          shift_d   = sel_word >> 1;
          sdata_d   = sel_word[0];
          bit_cnt_d = '0;
          rep_cnt_d = i_repeat;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bit_cnt_q == BIT_LAST) begin
          if (GAP > 0) begin
            gap_cnt_d = '0;
            state_d   = ST_GAP;
          end else if (rep_cnt_q != 4'd0) begin
            rep_cnt_d = rep_cnt_q - 4'd1;
            shift_d   = word_q >> 1;
            sdata_d   = word_q[0];
            bit_cnt_d = '0;
          end else begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          sdata_d   = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          if (rep_cnt_q != 4'd0) begin
            rep_cnt_d = rep_cnt_q - 4'd1;
            shift_d   = word_q >> 1;
            sdata_d   = word_q[0];
            bit_cnt_d = '0;
            state_d   = ST_SHIFT;
          end else begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign o_ready = (state_q == ST_IDLE);
  assign o_busy  = (state_q != ST_IDLE);
  assign o_done  = done_q;
  assign s_data  = sdata_q;
  assign o_state = state_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx: one instance with GAP=2, one with GAP=0,
// a right-shifting loopback receiver that counts pattern hits on the GAP=2 stream.
module tb_serial_pattern_tx;

  localparam logic [8:0] PAT = 9'b101000111;

  logic       clk;
  logic       rst_n;
  logic       valid, sel;
  logic [8:0] data;
  logic [3:0] rep;
  logic       ready, s_data, busy, done;
  logic [1:0] state;

  logic       valid0, sel0;
  logic [8:0] data0;
  logic [3:0] rep0;
  logic       ready0, s_data0, busy0, done0;
  logic [1:0] state0;

  int checks = 0;
  int failures = 0;
  int hits = 0;
  int done_cnt = 0;
  int done0_cnt = 0;
  int snap_hits, snap_done, n;
  logic [8:0] rx_sr = '0;

  serial_pattern_tx #(.WIDTH(9), .PATTERN(PAT), .GAP(2), .IDLE_LEVEL(1'b0)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_data(data),
    .i_sel_pattern(sel), .i_repeat(rep), .o_ready(ready), .s_data(s_data),
    .o_busy(busy), .o_done(done), .o_state(state)
  );

  serial_pattern_tx #(.WIDTH(9), .PATTERN(PAT), .GAP(0), .IDLE_LEVEL(1'b0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid0), .i_data(data0),
    .i_sel_pattern(sel0), .i_repeat(rep0), .o_ready(ready0), .s_data(s_data0),
    .o_busy(busy0), .o_done(done0), .o_state(state0)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // loopback receiver: new bit enters the MSB
  always @(posedge clk) begin
    rx_sr = {s_data, rx_sr[8:1]};
    if (rx_sr == PAT) hits++;
    if (done) done_cnt++;
    if (done0) done0_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_frame(input string tag, input int which, input logic [8:0] w);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("%s_bit%0d", tag, i), 32'(which == 0 ? s_data : s_data0), 32'(w[i]));
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    valid = 1'b0; sel = 1'b0; data = '0; rep = '0;
    valid0 = 1'b0; sel0 = 1'b0; data0 = '0; rep0 = '0;
    #3;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sdata", 32'(s_data), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // single pattern frame
    snap_hits = hits;
    valid = 1'b1; sel = 1'b1; rep = 4'd0;
    tick();
    valid = 1'b0; sel = 1'b0;
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_ready_shift", 32'(ready), 32'd0);
    expect_frame("t1", 0, PAT);
    check("t1_gap0", 32'(s_data), 32'd0);
    check("t1_ready_gap", 32'(ready), 32'd0);
    tick();
    check("t1_gap1", 32'(s_data), 32'd0);
    tick();
    check("t1_done", 32'(done), 32'd1);
    check("t1_ready_end", 32'(ready), 32'd1);
    check("t1_busy_end", 32'(busy), 32'd0);
    tick();
    check("t1_done_pulse", 32'(done), 32'd0);
    check("t1_hits", 32'(hits - snap_hits), 32'd1);

    // 0x0FF must never look like the pattern
    snap_hits = hits;
    valid = 1'b1; data = 9'h0FF; rep = 4'd0;
    tick();
    valid = 1'b0;
    expect_frame("t2", 0, 9'h0FF);
    tick(); tick(); tick();
    check("t2_hits", 32'(hits - snap_hits), 32'd0);

    // three repetitions: 3*9 + 3*2 busy cycles, one done, three hits
    snap_hits = hits; snap_done = done_cnt;
    valid = 1'b1; sel = 1'b1; rep = 4'd2;
    tick();
    valid = 1'b0; sel = 1'b0; rep = 4'd0;
    n = 0;
    while (busy && n < 100) begin n++; tick(); end
    check("t3_busy_cycles", 32'(n), 32'd33);
    check("t3_done", 32'(done), 32'd1);
    tick();
    check("t3_hits", 32'(hits - snap_hits), 32'd3);
    check("t3_done_count", 32'(done_cnt - snap_done), 32'd1);

    // request during SHIFT is ignored
    valid = 1'b1; data = 9'h1A5;
    tick();
    valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i == 2) begin data = 9'h000; valid = 1'b1; end
      if (i == 3) valid = 1'b0;
      check($sformatf("t4_bit%0d", i), 32'(s_data), 32'(i == 0 || i == 2 || i == 5 || i == 7 || i == 8));
      tick();
    end
    tick(); tick();
    check("t4_done", 32'(done), 32'd1);
    tick();
    check("t4_idle_after", 32'(busy), 32'd0);

    // asynchronous reset during bit 4
    snap_done = done_cnt;
    valid = 1'b1; data = 9'h155;
    tick();
    valid = 1'b0;
    tick(); tick(); tick(); tick();
    check("t5_bit4", 32'(s_data), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_sdata", 32'(s_data), 32'd0);
    check("t5_async_ready", 32'(ready), 32'd1);
    check("t5_async_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    check("t5_no_done", 32'(done), 32'd0);
    check("t5_done_count", 32'(done_cnt - snap_done), 32'd0);
    valid = 1'b1; sel = 1'b1;
    tick();
    valid = 1'b0; sel = 1'b0;
    expect_frame("t5_after", 0, PAT);
    tick(); tick();
    check("t5_after_done", 32'(done), 32'd1);

    // GAP=0, valid held: one IDLE cycle between frames, data sampled at accept
    valid0 = 1'b1; data0 = 9'h1C3; rep0 = 4'd0;
    tick();
    data0 = 9'h1FF;
    expect_frame("t6_a", 1, 9'h1C3);
    check("t6_idle_sdata", 32'(s_data0), 32'd0);
    check("t6_idle_ready", 32'(ready0), 32'd1);
    check("t6_idle_done", 32'(done0), 32'd1);
    data0 = 9'h02D;
    tick();
    data0 = 9'h1FF;
    expect_frame("t6_c", 1, 9'h02D);
    valid0 = 1'b0;
    check("t6_end_done", 32'(done0), 32'd1);
    tick();
    check("t6_end_idle", 32'(busy0), 32'd0);

    // sixteen back-to-back frames from i_repeat=15
    snap_done = done0_cnt;
    valid0 = 1'b1; data0 = 9'h1C3; rep0 = 4'd15;
    tick();
    valid0 = 1'b0; rep0 = 4'd0;
    n = 0;
    while (busy0 && n < 400) begin n++; tick(); end
    check("t7_busy_cycles", 32'(n), 32'd144);
    check("t7_done", 32'(done0), 32'd1);
    tick();
    check("t7_done_count", 32'(done0_cnt - snap_done), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
